// File: rtl/anton_pm_pkg.sv
// Shared encodings and helpers for the nibble-serial plus/minus accumulator bank.
package anton_pm_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OPERAND = 2'd1;
    localparam logic [1:0] EXEC    = 2'd2;
    localparam logic [1:0] READOUT = 2'd3;

    // Largest (neg=0) or smallest (neg=1) two's-complement value of 'width' bits,
    // returned in the low 'width' bits of a 32-bit word.
    function automatic logic [31:0] signed_limit(input int unsigned width, input logic neg);
        logic [31:0] max_v;
        max_v = (32'd1 << (width - 32'd1)) - 32'd1;
        return neg ? ~max_v : max_v;
    endfunction

endpackage

// File: rtl/anton_pm_alu.sv
// Combinational LOAD/ADD/SUB datapath with optional saturation on signed overflow.
module anton_pm_alu
    import anton_pm_pkg::*;
#(
    parameter int unsigned ACC_W    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] operand,
    input  logic [1:0]       op,
    output logic [ACC_W-1:0] next_value,
    output logic             overflow
);

    localparam logic [31:0]      MAX32 = signed_limit(ACC_W, 1'b0);
    localparam logic [31:0]      MIN32 = signed_limit(ACC_W, 1'b1);
    localparam logic [ACC_W-1:0] MAX_V = MAX32[ACC_W-1:0];
    localparam logic [ACC_W-1:0] MIN_V = MIN32[ACC_W-1:0];

    logic [ACC_W:0] wide;

    // One guard bit: overflow iff the two top bits of the sum disagree.
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {acc[ACC_W-1], acc} + {operand[ACC_W-1], operand};
            OP_SUB:  wide = {acc[ACC_W-1], acc} - {operand[ACC_W-1], operand};
            default: wide = {operand[ACC_W-1], operand};
        endcase
        overflow = wide[ACC_W] ^ wide[ACC_W-1];
        if (overflow && SATURATE)
            next_value = wide[ACC_W] ? MIN_V : MAX_V;
        else
            next_value = wide[ACC_W-1:0];
    end

endmodule

// File: rtl/anton_plus_minus_n.sv
// Nibble-serial command FSM, operand shifter, accumulator bank and byte readout.
module anton_plus_minus_n
    import anton_pm_pkg::*;
#(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned N_ACC    = 4,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [3:0]       nibble,
    output logic             ready,
    output logic [7:0]       result,
    output logic             result_valid,
    output logic [N_ACC-1:0] ovf
);

    localparam int unsigned NIB   = ACC_W / 4;
    localparam int unsigned NBYTE = ACC_W / 8;

    logic [1:0]       state;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_idx;
    logic [3:0]       nib_cnt;
    logic [2:0]       byte_cnt;
    logic [ACC_W-1:0] shift_reg;
    logic [ACC_W-1:0] snap;
    logic [ACC_W-1:0] acc [N_ACC];

    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W-1:0] read_sel;
    logic             read_idx_ok;
    logic [ACC_W-1:0] alu_next;
    logic             alu_ovf;

    assign ready = (state == IDLE) || (state == OPERAND);

    // acc_sel feeds the ALU for the latched command; read_sel snapshots on READ acceptance.
    always_comb begin
        acc_sel     = '0;
        read_sel    = '0;
        read_idx_ok = 1'b0;
        for (int unsigned i = 0; i < N_ACC; i++) begin
            if (cmd_idx == i[1:0])
                acc_sel = acc[i];
            if (nibble[1:0] == i[1:0]) begin
                read_sel    = acc[i];
                read_idx_ok = 1'b1;
            end
        end
    end

    anton_pm_alu #(
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
    ) u_alu (
        .acc       (acc_sel),
        .operand   (shift_reg),
        .op        (cmd_op),
        .next_value(alu_next),
        .overflow  (alu_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cmd_op       <= OP_LOAD;
            cmd_idx      <= '0;
            nib_cnt      <= '0;
            byte_cnt     <= '0;
            shift_reg    <= '0;
            snap         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf          <= '0;
            for (int unsigned i = 0; i < N_ACC; i++)
                acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        cmd_op   <= nibble[3:2];
                        cmd_idx  <= nibble[1:0];
                        nib_cnt  <= '0;
                        byte_cnt <= '0;
                        if (nibble[3:2] != OP_READ)
                            state <= OPERAND;
                        else if (read_idx_ok) begin
                            snap  <= read_sel;
                            state <= READOUT;
                        end
                    end
                end
                OPERAND: begin
                    if (valid) begin
                        shift_reg <= {shift_reg[ACC_W-5:0], nibble};
                        if (nib_cnt == 4'(NIB - 1))
                            state <= EXEC;
                        else
                            nib_cnt <= nib_cnt + 4'd1;
                    end
                end
                EXEC: begin
                    // Out-of-range indices match no slot, so the command silently does nothing.
                    for (int unsigned i = 0; i < N_ACC; i++) begin
                        if (cmd_idx == i[1:0]) begin
                            acc[i] <= alu_next;
                            if (cmd_op == OP_LOAD)
                                ovf[i] <= 1'b0;
                            else if (alu_ovf)
                                ovf[i] <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                READOUT: begin
                    if (byte_cnt == 3'(NBYTE)) begin
                        result       <= '0;
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        result       <= snap[ACC_W-1 -: 8];
                        result_valid <= 1'b1;
                        snap         <= snap << 8;
                        byte_cnt     <= byte_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_anton_plus_minus_n.sv
// Scoreboard bench: two instances (saturating and wrapping) share one directed stimulus stream.
module tb_anton_plus_minus_n;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] nibble = 4'h0;

    logic       ready0, ready1, rv0, rv1;
    logic [7:0] res0, res1;
    logic [3:0] ovf0, ovf1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    anton_plus_minus_n #(.ACC_W(16), .N_ACC(4), .SATURATE(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .valid(valid), .nibble(nibble),
        .ready(ready0), .result(res0), .result_valid(rv0), .ovf(ovf0)
    );

    anton_plus_minus_n #(.ACC_W(16), .N_ACC(4), .SATURATE(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .valid(valid), .nibble(nibble),
        .ready(ready1), .result(res1), .result_valid(rv1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rv0) begin
                if (q0.size() == 0) flag("dut0 unexpected result byte");
                else check("dut0 result byte", res0, q0.pop_front());
            end else
                check("dut0 result idle zero", res0, 0);
            if (rv1) begin
                if (q1.size() == 0) flag("dut1 unexpected result byte");
                else check("dut1 result byte", res1, q1.pop_front());
            end else
                check("dut1 result idle zero", res1, 0);
        end
    end

    // Offer one nibble; while ready is low, optionally keep valid high with a junk READ.
    task automatic put(input logic [3:0] n, input int unsigned gap, input bit hold);
        int unsigned k;
        for (int unsigned g = 0; g < gap; g++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(negedge clk);
        k = 0;
        while (!ready0 && k < 64) begin
            valid  = hold;
            nibble = 4'hC;
            @(negedge clk);
            k++;
        end
        if (!ready0) flag("ready timeout");
        valid  = 1'b1;
        nibble = n;
    endtask

    task automatic op(input logic [1:0] o, input logic [1:0] idx, input logic [15:0] val,
                      input bit gaps, input bit hold);
        logic [3:0] nib;
        put({o, idx}, 0, hold);
        for (int k = 0; k < 4; k++) begin
            nib = val[15 - 4*k -: 4];
            put(nib, gaps ? $urandom_range(0, 3) : 0, hold);
        end
    endtask

    task automatic rd(input logic [1:0] idx, input logic [15:0] e0, input logic [15:0] e1,
                      input bit hold);
        put({2'b11, idx}, 0, hold);
        q0.push_back(e0[15:8]);
        q0.push_back(e0[7:0]);
        q1.push_back(e1[15:8]);
        q1.push_back(e1[7:0]);
    endtask

    task automatic drain();
        int unsigned k;
        @(negedge clk);
        valid = 1'b0;
        k = 0;
        while ((!ready0 || q0.size() != 0 || q1.size() != 0) && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("dut0 queue drained", q0.size(), 0);
        check("dut1 queue drained", q1.size(), 0);
        check("ready after drain", ready0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset ready", ready0, 1);
        check("reset result", res0, 0);
        check("reset result_valid", rv0, 0);
        check("reset ovf dut0", ovf0, 0);
        check("reset ovf dut1", ovf1, 0);
        reset_n = 1'b1;

        // READ acc0 after reset; ready comes back on the third edge after acceptance
        rd(2'd0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk); valid = 1'b0;
        check("read ready cycle1", ready0, 0);
        @(negedge clk);
        check("read ready cycle2", ready0, 0);
        @(negedge clk);
        check("read ready cycle3", ready0, 0);
        @(negedge clk);
        check("read ready back", ready0, 1);
        check("ovf after first read", ovf0, 0);

        op(2'b00, 2'd1, 16'h1234, 1'b0, 1'b0);
        op(2'b01, 2'd1, 16'h0FFF, 1'b0, 1'b0);
        rd(2'd1, 16'h2233, 16'h2233, 1'b0);
        drain();
        check("ovf1 clean add", ovf0[1], 0);

        op(2'b00, 2'd2, 16'h7FF0, 1'b0, 1'b0);
        op(2'b01, 2'd2, 16'h0020, 1'b0, 1'b0);
        rd(2'd2, 16'h7FFF, 16'h8010, 1'b0);
        drain();
        check("dut0 ovf2 set", ovf0, 4'b0100);
        check("dut1 ovf2 set", ovf1, 4'b0100);
        op(2'b10, 2'd2, 16'h0001, 1'b0, 1'b0);
        rd(2'd2, 16'h7FFE, 16'h800F, 1'b0);
        drain();
        check("dut0 ovf2 sticky", ovf0, 4'b0100);
        check("dut1 ovf2 sticky", ovf1, 4'b0100);
        op(2'b00, 2'd2, 16'h0000, 1'b0, 1'b0);
        drain();
        check("dut0 ovf2 cleared by load", ovf0, 4'b0000);
        check("dut1 ovf2 cleared by load", ovf1, 4'b0000);

        op(2'b00, 2'd0, 16'h7FF0, 1'b0, 1'b0);
        op(2'b01, 2'd0, 16'h0020, 1'b0, 1'b0);
        rd(2'd0, 16'h7FFF, 16'h8010, 1'b0);
        drain();
        check("dut0 ovf0 positive", ovf0, 4'b0001);
        check("dut1 ovf0 positive", ovf1, 4'b0001);
        op(2'b00, 2'd0, 16'h8005, 1'b0, 1'b0);
        op(2'b10, 2'd0, 16'h0010, 1'b0, 1'b0);
        rd(2'd0, 16'h8000, 16'h7FF5, 1'b0);
        drain();
        check("dut0 ovf0 negative", ovf0, 4'b0001);
        check("dut1 ovf0 negative", ovf1, 4'b0001);

        // Gaps between operands and valid held high while ready is low
        op(2'b00, 2'd1, 16'h1234, 1'b1, 1'b1);
        op(2'b01, 2'd1, 16'h0FFF, 1'b1, 1'b1);
        rd(2'd1, 16'h2233, 16'h2233, 1'b1);
        rd(2'd2, 16'h0000, 16'h0000, 1'b1);
        drain();
        check("dut0 ovf after gapped run", ovf0, 4'b0001);

        // Reset partway through LOAD acc3 0xABCD
        put(4'b0011, 0, 1'b0);
        put(4'hA, 0, 1'b0);
        put(4'hB, 0, 1'b0);
        @(negedge clk);
        valid   = 1'b0;
        reset_n = 1'b0;
        #1;
        check("ready during reset", ready0, 1);
        check("result_valid during reset", rv0, 0);
        check("ovf cleared by reset", ovf0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check("ready after reset", ready0, 1);
        rd(2'd3, 16'h0000, 16'h0000, 1'b0);
        rd(2'd1, 16'h0000, 16'h0000, 1'b0);
        drain();
        op(2'b00, 2'd3, 16'h0042, 1'b0, 1'b0);
        rd(2'd3, 16'h0042, 16'h0042, 1'b0);
        drain();
        check("dut1 ovf after reset load", ovf1, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
